// File: rtl/btn_event_reporter_if.sv
// Byte-level link between spi_dev_core (master) and btn_event_reporter (slave).
// The master drives received bytes, transaction edges and acks; the slave drives the MISO byte.
interface btn_event_reporter_if;
   logic [7:0] usr_mosi_data;
   logic       usr_mosi_stb;
   logic [7:0] usr_miso_data;
   logic       usr_miso_ack;
   logic       csn_fall;
   logic       csn_rise;

   modport master (
      output usr_mosi_data,
      output usr_mosi_stb,
      output usr_miso_ack,
      output csn_fall,
      output csn_rise,
      input  usr_miso_data
   );

   modport slave (
      input  usr_mosi_data,
      input  usr_mosi_stb,
      input  usr_miso_ack,
      input  csn_fall,
      input  csn_rise,
      output usr_miso_data
   );
endinterface

// File: rtl/btn_event_reporter.sv
// Queues button-word change events in a FIFO and streams them to the host over SPI reads.
// Reads are speculative; entries are only retired when a read command completes.
module btn_event_reporter #(
   parameter int unsigned Log2Depth = 4,
   parameter logic [7:0]  CmdRead   = 8'hF5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [10:0]                btn_state_i,
   btn_event_reporter_if.slave        bus,
   output logic                       irq_o,
   output logic                       overflow_o
);

   localparam int unsigned Depth = 1 << Log2Depth;
   localparam int unsigned PtrW  = Log2Depth + 1;

   typedef enum logic [1:0] {
      StIdle,
      StStat,
      StHi,
      StLo
   } state_e;

   state_e state_q, state_d;

   logic [10:0]     prev_q;
   logic [15:0]     mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] spec_ptr_q, spec_ptr_d;
   logic [3:0]      seq_q, seq_d;
   logic            overflow_q, overflow_d;
   logic            ovf_snap_q, ovf_snap_d;
   logic            irq_q;
   logic            cmd_ok_q, cmd_ok_d;
   logic            cmd_seen_q, cmd_seen_d;
   logic            have_q, have_d;
   logic [7:0]      miso_q, miso_d;

   logic [PtrW-1:0] count;
   logic [4:0]      count5;
   logic            full;
   logic            change;
   logic            do_write;
   logic            do_drop;
   logic            active;
   logic            end_xfer;
   logic            commit;
   logic [PtrW-1:0] spec_next;
   logic            avail;
   logic            avail_next;
   logic [15:0]     head;
   logic [15:0]     head_next;

   // FIFO status and change detection
   always_comb begin
      count    = wr_ptr_q - rd_ptr_q;
      count5   = 5'(count);
      full     = (count == PtrW'(Depth));
      change   = (btn_state_i != prev_q);
      do_write = change & ~full;
      do_drop  = change & full;
      active   = (state_q != StIdle);
      end_xfer = bus.csn_rise & active;
      commit   = end_xfer & cmd_ok_q;
   end

   // Read-side view: current head and the entry after it for the LO->HI step
   always_comb begin
      spec_next  = have_q ? spec_ptr_q + PtrW'(1) : spec_ptr_q;
      avail      = (spec_ptr_q != wr_ptr_q);
      avail_next = (spec_next != wr_ptr_q);
      head       = mem_q[spec_ptr_q[Log2Depth-1:0]];
      head_next  = mem_q[spec_next[Log2Depth-1:0]];
   end

   // Pointer, sequence and overflow bookkeeping
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      seq_d      = seq_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (do_write) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
         seq_d    = seq_q + 4'd1;
      end
      if (commit) begin
         rd_ptr_d = spec_ptr_q;
      end
      // A drop in the commit cycle keeps the flag set
      if (do_drop) begin
         overflow_d = 1'b1;
      end else if (commit && ovf_snap_q) begin
         overflow_d = 1'b0;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (end_xfer) begin
         state_d = StIdle;
      end else if (bus.csn_fall) begin
         state_d = StStat;
      end else if (bus.usr_miso_ack) begin
         case (state_q)
            StStat:  state_d = StHi;
            StHi:    state_d = StLo;
            StLo:    state_d = StHi;
            default: state_d = state_q;
         endcase
      end
   end

   // FSM: outputs and per-transaction context
   always_comb begin
      miso_d     = miso_q;
      spec_ptr_d = spec_ptr_q;
      have_d     = have_q;
      ovf_snap_d = ovf_snap_q;
      cmd_ok_d   = cmd_ok_q;
      cmd_seen_d = cmd_seen_q;
      if (end_xfer) begin
         miso_d = 8'h00;
      end else if (bus.csn_fall) begin
         miso_d     = {overflow_q, 2'b00, count5};
         spec_ptr_d = rd_ptr_q;
         ovf_snap_d = overflow_q;
         cmd_ok_d   = 1'b0;
         cmd_seen_d = 1'b0;
      end else begin
         if (bus.usr_miso_ack) begin
            case (state_q)
               StStat: begin
                  have_d = avail;
                  miso_d = avail ? head[15:8] : 8'h00;
               end
               StHi: begin
                  miso_d = have_q ? head[7:0] : 8'h00;
               end
               StLo: begin
                  // Entry is consumed only once its LO byte has been taken
                  spec_ptr_d = spec_next;
                  have_d     = avail_next;
                  miso_d     = avail_next ? head_next[15:8] : 8'h00;
               end
               default: begin
                  miso_d = miso_q;
               end
            endcase
         end
         if (bus.usr_mosi_stb && active && !cmd_seen_q) begin
            cmd_seen_d = 1'b1;
            cmd_ok_d   = (bus.usr_mosi_data == CmdRead);
         end
      end
   end

   // FSM: state and context registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         prev_q     <= 11'h000;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         spec_ptr_q <= '0;
         seq_q      <= 4'd0;
         overflow_q <= 1'b0;
         ovf_snap_q <= 1'b0;
         irq_q      <= 1'b0;
         cmd_ok_q   <= 1'b0;
         cmd_seen_q <= 1'b0;
         have_q     <= 1'b0;
         miso_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         prev_q     <= btn_state_i;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         spec_ptr_q <= spec_ptr_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
         ovf_snap_q <= ovf_snap_d;
         irq_q      <= (wr_ptr_q != rd_ptr_q);
         cmd_ok_q   <= cmd_ok_d;
         cmd_seen_q <= cmd_seen_d;
         have_q     <= have_d;
         miso_q     <= miso_d;
      end
   end

   // Storage has no reset; pointers define what is valid
   always_ff @(posedge clk) begin
      if (!rst && do_write) begin
         mem_q[wr_ptr_q[Log2Depth-1:0]] <= {1'b1, seq_q, btn_state_i};
      end
   end

   assign bus.usr_miso_data = miso_q;
   assign irq_o             = irq_q;
   assign overflow_o        = overflow_q;

endmodule
